// File: rtl/psram_burst_arbiter_pkg.sv
// Shared types and constants for the PSRAM burst arbiter: FSM states,
// command encodings, bus widths and the two-requester pick function.
package psram_arb_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WR_BURST  = 3'd2,
    ST_RD_WAIT   = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  // Returns {write_wins, read_wins}; a tie goes to whoever was not served last.
  function automatic logic [1:0] arb_pick(input logic wr_req, input logic rd_req,
                                          input logic last_wr);
    logic [1:0] pick;
    if (wr_req && rd_req) begin
      pick = last_wr ? 2'b01 : 2'b10;
    end else begin
      pick = {wr_req, rd_req};
    end
    return pick;
  endfunction

endpackage

// File: rtl/burst_spacing_counter.sv
// Counts cycles since the last command strobe and flags when the controller's
// minimum command spacing has elapsed. Saturates rather than wrapping.
module burst_spacing_counter #(
  parameter int CMD_GAP = 14
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  output logic o_gap_ok
);

  localparam int CNT_W = $clog2(CMD_GAP + 1);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(CMD_GAP);

  logic [CNT_W-1:0] r_cnt;

  // Spacing counter: one cycle has elapsed by the cycle after the strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != GAP_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_gap_ok = (r_cnt == GAP_MAX);

endmodule

// File: rtl/psram_burst_arbiter.sv
// Shares one PSRAM controller channel between the camera write path and the
// LCD read path: fair arbitration, beat pumping, command spacing, error flag.
module psram_burst_arbiter
  import psram_arb_pkg::*;
#(
  parameter int BURST_WORDS = 8,
  parameter int CMD_GAP     = 14,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_done,
  output logic              cmd,
  output logic              cmd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [3:0]        data_mask,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_data_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              wr_grant,
  output logic              wr_pop,
  input  logic [DATA_W-1:0] wr_data_in,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic [DATA_W-1:0] rd_beat,
  output logic              rd_beat_valid,
  output logic              busy,
  output logic              error
);

  localparam int BEAT_W = $clog2(BURST_WORDS + 1);
  localparam int TO_W   = $clog2(RD_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_WORDS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RD_TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(RD_TIMEOUT);

  arb_state_e r_state;
  arb_state_e w_next_state;

  logic [BEAT_W-1:0] r_beat_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_last_wr;
  logic              r_cmd;
  logic              r_cmd_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_grant;
  logic              r_rd_grant;
  logic [DATA_W-1:0] r_rd_beat;
  logic              r_rd_beat_valid;
  logic              r_busy;
  logic              r_error;

  logic [1:0] w_pick;
  logic       w_wr_win;
  logic       w_rd_win;
  logic       w_rd_timeout;
  logic       w_beat_take;
  logic       w_spurious;
  logic       w_gap_ok;

  burst_spacing_counter #(
    .CMD_GAP (CMD_GAP)
  ) u_spacing (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (r_cmd_en),
    .o_gap_ok (w_gap_ok)
  );

  assign w_pick     = arb_pick(wr_req, rd_req, r_last_wr);
  assign w_spurious = rd_data_valid && (r_state != ST_RD_WAIT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a beat on the final timeout cycle still completes the burst.
  always_comb begin
    w_next_state = r_state;
    w_wr_win     = 1'b0;
    w_rd_win     = 1'b0;
    w_rd_timeout = 1'b0;
    w_beat_take  = 1'b0;
    case (r_state)
      ST_INIT_WAIT: begin
        if (init_done) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_INIT_WAIT;
        end
      end
      ST_IDLE: begin
        if (!init_done) begin
          w_next_state = ST_INIT_WAIT;
        end else if (w_pick[1]) begin
          w_wr_win     = 1'b1;
          w_next_state = ST_WR_BURST;
        end else if (w_pick[0]) begin
          w_rd_win     = 1'b1;
          w_next_state = ST_RD_WAIT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (r_beat_cnt >= BEAT_LAST) begin
          w_next_state = ST_GAP;
        end else begin
          w_next_state = ST_WR_BURST;
        end
      end
      ST_RD_WAIT: begin
        w_beat_take = rd_data_valid;
        if (rd_data_valid && (r_beat_cnt >= BEAT_LAST)) begin
          w_next_state = ST_GAP;
        end else if (r_to_cnt >= TO_LAST) begin
          w_rd_timeout = 1'b1;
          w_next_state = ST_GAP;
        end else begin
          w_next_state = ST_RD_WAIT;
        end
      end
      ST_GAP: begin
        if (w_gap_ok) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_GAP;
        end
      end
      default: begin
        w_next_state = ST_INIT_WAIT;
      end
    endcase
  end

  // Output decode: write beats stream straight from the FWFT source.
  always_comb begin
    if (r_state == ST_WR_BURST) begin
      wr_pop  = 1'b1;
      wr_data = wr_data_in;
    end else begin
      wr_pop  = 1'b0;
      wr_data = '0;
    end
  end

  // Beat/timeout counters and the last-served pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt <= '0;
      r_to_cnt   <= '0;
      r_last_wr  <= CMD_READ;
    end else begin
      case (r_state)
        ST_WR_BURST: r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
        ST_RD_WAIT: begin
          if (w_beat_take) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end else begin
            r_beat_cnt <= r_beat_cnt;
          end
        end
        default: r_beat_cnt <= '0;
      endcase
      if (r_state != ST_RD_WAIT) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_MAX) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= r_to_cnt;
      end
      if (w_wr_win) begin
        r_last_wr <= CMD_WRITE;
      end else if (w_rd_win) begin
        r_last_wr <= CMD_READ;
      end else begin
        r_last_wr <= r_last_wr;
      end
    end
  end

  // Registered command, grant, read-beat, busy and sticky error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd           <= 1'b0;
      r_cmd_en        <= 1'b0;
      r_addr          <= '0;
      r_wr_grant      <= 1'b0;
      r_rd_grant      <= 1'b0;
      r_rd_beat       <= '0;
      r_rd_beat_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_cmd_en   <= w_wr_win | w_rd_win;
      r_wr_grant <= w_wr_win;
      r_rd_grant <= w_rd_win;
      if (w_wr_win) begin
        r_cmd  <= CMD_WRITE;
        r_addr <= wr_addr;
      end else if (w_rd_win) begin
        r_cmd  <= CMD_READ;
        r_addr <= rd_addr;
      end else begin
        r_cmd  <= r_cmd;
        r_addr <= r_addr;
      end
      r_rd_beat_valid <= w_beat_take;
      if (w_beat_take) begin
        r_rd_beat <= rd_data;
      end else begin
        r_rd_beat <= r_rd_beat;
      end
      r_busy <= (w_next_state != ST_IDLE);
      if (w_rd_timeout || w_spurious) begin
        r_error <= 1'b1;
      end else begin
        r_error <= r_error;
      end
    end
  end

  assign cmd           = r_cmd;
  assign cmd_en        = r_cmd_en;
  assign addr          = r_addr;
  assign data_mask     = 4'h0;
  assign wr_grant      = r_wr_grant;
  assign rd_grant      = r_rd_grant;
  assign rd_beat       = r_rd_beat;
  assign rd_beat_valid = r_rd_beat_valid;
  assign busy          = r_busy;
  assign error         = r_error;

endmodule

// File: tb/tb_psram_burst_arbiter.sv
// Directed bench for psram_burst_arbiter: arbitration vector table plus
// hand-written init, fairness, timeout, spurious-beat and reset sequences.
module tb_psram_burst_arbiter;

  localparam int BW  = 8;
  localparam int GAP = 14;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_done;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        wr_req;
  logic [20:0] wr_addr;
  logic        wr_grant;
  logic        wr_pop;
  logic [31:0] wr_data_in;
  logic        rd_req;
  logic [20:0] rd_addr;
  logic        rd_grant;
  logic [31:0] rd_beat;
  logic        rd_beat_valid;
  logic        busy;
  logic        error;

  psram_burst_arbiter #(
    .BURST_WORDS (BW),
    .CMD_GAP     (GAP),
    .RD_TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init_done     (init_done),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_grant      (wr_grant),
    .wr_pop        (wr_pop),
    .wr_data_in    (wr_data_in),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_grant      (rd_grant),
    .rd_beat       (rd_beat),
    .rd_beat_valid (rd_beat_valid),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [20:0] waddr;
    logic [20:0] raddr;
    logic        exp_wr;
    logic [20:0] exp_addr;
    int          delay;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int failures = 0;
  int t_prev = 0;
  logic have_prev = 1'b0;
  int t;
  int t0;
  int nce;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cmd_en(output int tc);
    int n = 0;
    @(negedge clk);
    while (cmd_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_en_seen", 32'(cmd_en), 32'd1);
    tc = cyc;
    if (have_prev) chk("cmd_spacing", 32'((tc - t_prev) >= GAP), 32'd1);
    t_prev    = tc;
    have_prev = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_grant(input logic exp_wr, input logic [20:0] exp_addr);
    chk("cmd", 32'(cmd), 32'(exp_wr));
    chk("addr", 32'(addr), 32'(exp_addr));
    chk("wr_grant", 32'(wr_grant), 32'(exp_wr));
    chk("rd_grant", 32'(rd_grant), 32'(!exp_wr));
  endtask

  // Called on the cmd_en cycle; wr_data_in already presents word 0.
  task automatic run_write(input logic [31:0] base);
    for (int i = 0; i < BW; i++) begin
      if (i > 0) @(negedge clk);
      chk("wr_pop", 32'(wr_pop), 32'd1);
      chk("wr_data", wr_data, base + 32'(i));
      if (i == 1) chk("cmd_en_pulse", 32'(cmd_en), 32'd0);
      wr_data_in = base + 32'(i + 1);
    end
    @(negedge clk);
    chk("wr_pop_end", 32'(wr_pop), 32'd0);
  endtask

  task automatic run_read(input int delay, input int nbeats, input logic [31:0] base);
    repeat (delay) @(negedge clk);
    for (int i = 0; i < nbeats; i++) begin
      rd_data_valid = 1'b1;
      rd_data       = base + 32'(i);
      @(negedge clk);
      chk("rd_beat_valid", 32'(rd_beat_valid), 32'd1);
      chk("rd_beat", rd_beat, base + 32'(i));
    end
    rd_data_valid = 1'b0;
    rd_data       = '0;
    @(negedge clk);
    chk("rd_beat_valid_end", 32'(rd_beat_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 21'h00000, 21'h00100, 1'b0, 21'h00100, 20};
    vecs[1] = '{1'b1, 1'b1, 21'h01234, 21'h00200, 1'b1, 21'h01234, 0};
    vecs[2] = '{1'b1, 1'b1, 21'h01300, 21'h00300, 1'b0, 21'h00300, 1};
    vecs[3] = '{1'b1, 1'b0, 21'h1FFFFF, 21'h00000, 1'b1, 21'h1FFFFF, 0};
    vecs[4] = '{1'b1, 1'b1, 21'h01500, 21'h00500, 1'b0, 21'h00500, 0};
    vecs[5] = '{1'b0, 1'b1, 21'h00000, 21'h00600, 1'b0, 21'h00600, 5};
    vecs[6] = '{1'b1, 1'b1, 21'h01700, 21'h00700, 1'b1, 21'h01700, 0};
    vecs[7] = '{1'b1, 1'b0, 21'h01800, 21'h00000, 1'b1, 21'h01800, 0};

    reset = 1'b1; init_done = 1'b0; rd_data = '0; rd_data_valid = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data_in = '0; rd_req = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_en", 32'(cmd_en), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_data_mask", 32'(data_mask), 32'd0);
    chk("rst_wr_grant", 32'(wr_grant), 32'd0);
    chk("rst_rd_grant", 32'(rd_grant), 32'd0);
    chk("rst_wr_pop", 32'(wr_pop), 32'd0);
    chk("rst_rd_beat", rd_beat, 32'd0);
    chk("rst_rd_beat_valid", 32'(rd_beat_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Init gating: request held for 50 cycles without calibration.
    reset = 1'b0; wr_req = 1'b1; wr_addr = 21'h0AAAA; wr_data_in = 32'h1000_0000;
    nce = 0;
    repeat (50) begin
      @(negedge clk);
      if (cmd_en === 1'b1) nce++;
    end
    chk("init_no_cmd_en", 32'(nce), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    init_done = 1'b1;
    @(negedge clk);
    chk("init_lat1_cmd_en", 32'(cmd_en), 32'd0);
    @(negedge clk);
    chk("init_lat2_cmd_en", 32'(cmd_en), 32'd1);
    t_prev = cyc; have_prev = 1'b1;
    check_grant(1'b1, 21'h0AAAA);
    wr_req = 1'b0;
    run_write(32'h1000_0000);

    // Arbitration table; last served is write after the init burst.
    for (int r = 0; r < 8; r++) begin
      wr_req = vecs[r].wr; rd_req = vecs[r].rd;
      wr_addr = vecs[r].waddr; rd_addr = vecs[r].raddr;
      wr_data_in = 32'h2000_0000 + 32'(r << 8);
      wait_cmd_en(t);
      check_grant(vecs[r].exp_wr, vecs[r].exp_addr);
      wr_req = 1'b0; rd_req = 1'b0;
      if (vecs[r].exp_wr) run_write(32'h2000_0000 + 32'(r << 8));
      else run_read(vecs[r].delay, BW, 32'hA5A5_0000 + 32'(r << 8));
      chk("no_error", 32'(error), 32'd0);
    end

    // Both requests held continuously: R, W, R, W.
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 21'h02000; rd_addr = 21'h03000;
    for (int i = 0; i < 4; i++) begin
      logic exp_wr;
      exp_wr = (i % 2 == 1);
      wr_data_in = 32'h4000_0000 + 32'(i << 8);
      wait_cmd_en(t);
      check_grant(exp_wr, exp_wr ? 21'h02000 : 21'h03000);
      if (i == 3) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
      if (exp_wr) run_write(32'h4000_0000 + 32'(i << 8));
      else run_read(3, BW, 32'h5A5A_0000 + 32'(i << 8));
    end

    // Spurious beat while idle.
    wait_idle();
    chk("pre_spurious_error", 32'(error), 32'd0);
    rd_data_valid = 1'b1; rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rd_data_valid = 1'b0; rd_data = '0;
    chk("spurious_error", 32'(error), 32'd1);
    chk("spurious_no_beat", 32'(rd_beat_valid), 32'd0);

    // Read timeout: only 5 beats returned.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; rd_req = 1'b1; rd_addr = 21'h00ABC; have_prev = 1'b0;
    wait_cmd_en(t0);
    check_grant(1'b0, 21'h00ABC);
    rd_req = 1'b0;
    run_read(2, 5, 32'hC0DE_0000);
    while (cyc < t0 + TO - 1) @(negedge clk);
    chk("timeout_error_before", 32'(error), 32'd0);
    @(negedge clk);
    chk("timeout_error_at", 32'(error), 32'd1);
    rd_data_valid = 1'b1; rd_data = 32'hC0DE_0005;
    @(negedge clk);
    rd_data_valid = 1'b0; rd_data = '0;
    chk("late_beat_dropped", 32'(rd_beat_valid), 32'd0);
    wait_idle();
    chk("timeout_error_sticky", 32'(error), 32'd1);

    // Reset during beat 3 of a write burst.
    wr_req = 1'b1; wr_addr = 21'h0F0F0; wr_data_in = 32'h3000_0000;
    wait_cmd_en(t);
    check_grant(1'b1, 21'h0F0F0);
    wr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("mid_wr_pop", 32'(wr_pop), 32'd1);
      wr_data_in = 32'h3000_0000 + 32'(i + 1);
    end
    reset = 1'b1; init_done = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_pop", 32'(wr_pop), 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_cmd_en", 32'(cmd_en), 32'd0);
    chk("mid_rst_addr", 32'(addr), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    chk("mid_rst_rd_beat", rd_beat, 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; wr_req = 1'b1;
    nce = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_en === 1'b1) nce++;
    end
    chk("post_rst_no_cmd_en", 32'(nce), 32'd0);
    chk("post_rst_init_wait", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
